// File: rtl/exp5_unidade_controle_rodadas_pkg.sv
// Shared definitions for the round-based sequence memory control unit.
// The state codes double as the debug code shown on the hex display.
package exp5_unidade_controle_rodadas_pkg;

    typedef enum logic [3:0] {
        INICIAL        = 4'h0,
        PREPARACAO     = 4'h1,
        INICIO_RODADA  = 4'h2,
        ESPERA_JOGADA  = 4'h3,
        REGISTRA       = 4'h4,
        COMPARACAO     = 4'h5,
        PROXIMA_JOGADA = 4'h6,
        PROXIMA_RODADA = 4'h7,
        FINAL_ACERTOU  = 4'hA,
        FINAL_TIMEOUT  = 4'hC,
        FINAL_ERROU    = 4'hE
    } estado_t;

    // Debug code shown when the state register holds an unassigned value
    localparam logic [3:0] COD_INVALIDO = 4'hF;

endpackage

// File: rtl/exp5_contador_timeout.sv
// Play-timeout counter: counts cycles while enabled, clears when told to.
// fim flags the last allowed cycle (count == M-1) while counting.
module exp5_contador_timeout #(
    parameter int M = 3000
) (
    input  logic clock,
    input  logic zera,
    input  logic conta,
    output logic fim
);

    localparam int W = (M > 1) ? $clog2(M) : 1;
    localparam logic [W-1:0] ULTIMO = W'(M - 1);

    logic [W-1:0] contagem;

    // Clear has priority so every entry into the wait state starts from zero
    always_ff @(posedge clock) begin
        if (zera) begin
            contagem <= '0;
        end else if (conta) begin
            contagem <= contagem + W'(1);
        end
    end

    assign fim = conta && (contagem == ULTIMO);

endmodule

// File: rtl/exp5_unidade_controle_rodadas.sv
// Moore control unit for the multi-round sequence memory game.
// Drives the address (E), limit (L) and play (R) datapath registers and
// owns the play-timeout counter. Outputs depend on the state register only.
module exp5_unidade_controle_rodadas
    import exp5_unidade_controle_rodadas_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 3000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic       jogada,
    input  logic       igual,
    input  logic       fimE,
    input  logic       fimL,
    output logic       zeraE,
    output logic       contaE,
    output logic       zeraL,
    output logic       contaL,
    output logic       zeraR,
    output logic       registraR,
    output logic       pronto,
    output logic       ganhou,
    output logic       perdeu,
    output logic       timeout,
    output logic [3:0] db_estado
);

    estado_t estado;
    estado_t proximo;

    logic conta_timeout;
    logic zera_timeout;
    logic fim_timeout;

    // Timer runs only while waiting for a play; reset also clears it so a
    // reset taken in the wait state leaves the counter at zero.
    assign conta_timeout = (estado == ESPERA_JOGADA) && !reset;
    assign zera_timeout  = (estado != ESPERA_JOGADA) || reset;

    exp5_contador_timeout #(
        .M(TIMEOUT_CYCLES)
    ) u_timeout (
        .clock(clock),
        .zera (zera_timeout),
        .conta(conta_timeout),
        .fim  (fim_timeout)
    );

    // State register with synchronous reset
    always_ff @(posedge clock) begin
        if (reset) begin
            estado <= INICIAL;
        end else begin
            estado <= proximo;
        end
    end

    // Next-state logic; a play arriving on the expiry cycle beats the timeout
    always_comb begin
        proximo = INICIAL;
        case (estado)
            INICIAL:        proximo = iniciar ? PREPARACAO : INICIAL;
            PREPARACAO:     proximo = INICIO_RODADA;
            INICIO_RODADA:  proximo = ESPERA_JOGADA;
            ESPERA_JOGADA: begin
                if (jogada) begin
                    proximo = REGISTRA;
                end else if (fim_timeout) begin
                    proximo = FINAL_TIMEOUT;
                end else begin
                    proximo = ESPERA_JOGADA;
                end
            end
            REGISTRA:       proximo = COMPARACAO;
            COMPARACAO: begin
                if (!igual) begin
                    proximo = FINAL_ERROU;
                end else if (!fimE) begin
                    proximo = PROXIMA_JOGADA;
                end else if (!fimL) begin
                    proximo = PROXIMA_RODADA;
                end else begin
                    proximo = FINAL_ACERTOU;
                end
            end
            PROXIMA_JOGADA: proximo = ESPERA_JOGADA;
            PROXIMA_RODADA: proximo = INICIO_RODADA;
            FINAL_ACERTOU:  proximo = iniciar ? PREPARACAO : FINAL_ACERTOU;
            FINAL_ERROU:    proximo = iniciar ? PREPARACAO : FINAL_ERROU;
            FINAL_TIMEOUT:  proximo = iniciar ? PREPARACAO : FINAL_TIMEOUT;
            default:        proximo = INICIAL;
        endcase
    end

    // Moore outputs decoded from the current state
    always_comb begin
        zeraE     = 1'b0;
        contaE    = 1'b0;
        zeraL     = 1'b0;
        contaL    = 1'b0;
        zeraR     = 1'b0;
        registraR = 1'b0;
        pronto    = 1'b0;
        ganhou    = 1'b0;
        perdeu    = 1'b0;
        timeout   = 1'b0;
        db_estado = COD_INVALIDO;
        case (estado)
            INICIAL, PREPARACAO: begin
                zeraE     = 1'b1;
                zeraL     = 1'b1;
                zeraR     = 1'b1;
                db_estado = estado;
            end
            INICIO_RODADA: begin
                zeraE     = 1'b1;
                db_estado = estado;
            end
            ESPERA_JOGADA, COMPARACAO: begin
                db_estado = estado;
            end
            REGISTRA: begin
                registraR = 1'b1;
                db_estado = estado;
            end
            PROXIMA_JOGADA: begin
                contaE    = 1'b1;
                db_estado = estado;
            end
            PROXIMA_RODADA: begin
                contaL    = 1'b1;
                db_estado = estado;
            end
            FINAL_ACERTOU: begin
                pronto    = 1'b1;
                ganhou    = 1'b1;
                db_estado = estado;
            end
            FINAL_ERROU: begin
                pronto    = 1'b1;
                perdeu    = 1'b1;
                db_estado = estado;
            end
            FINAL_TIMEOUT: begin
                pronto    = 1'b1;
                perdeu    = 1'b1;
                timeout   = 1'b1;
                db_estado = estado;
            end
            default: begin
                db_estado = COD_INVALIDO;
            end
        endcase
    end

endmodule

// File: tb/tb_exp5_unidade_controle_rodadas.sv
// Bench for the sequence memory control unit: a small datapath environment
// (E, L, R registers and a 4-entry memory) reacts to the DUT strobes, and a
// game-level reference predicts state and outputs every cycle.
module tb_exp5_unidade_controle_rodadas;
    import exp5_unidade_controle_rodadas_pkg::*;

    localparam int T = 8;

    logic clock = 1'b0;
    logic reset, iniciar, jogada, igual, fimE, fimL;
    logic zeraE, contaE, zeraL, contaL, zeraR, registraR;
    logic pronto, ganhou, perdeu, timeout;
    logic [3:0] db_estado;

    exp5_unidade_controle_rodadas #(
        .TIMEOUT_CYCLES(T)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .iniciar  (iniciar),
        .jogada   (jogada),
        .igual    (igual),
        .fimE     (fimE),
        .fimL     (fimL),
        .zeraE    (zeraE),
        .contaE   (contaE),
        .zeraL    (zeraL),
        .contaL   (contaL),
        .zeraR    (zeraR),
        .registraR(registraR),
        .pronto   (pronto),
        .ganhou   (ganhou),
        .perdeu   (perdeu),
        .timeout  (timeout),
        .db_estado(db_estado)
    );

    always #5 clock = ~clock;

    // Datapath environment: 4 stored positions, last address 3
    logic [3:0] mem [4];
    logic [1:0] E, L;
    logic [3:0] R, play_val;

    always @(posedge clock) begin
        if (zeraE) E <= 2'd0; else if (contaE) E <= E + 2'd1;
        if (zeraL) L <= 2'd0; else if (contaL) L <= L + 2'd1;
        if (zeraR) R <= 4'd0; else if (registraR) R <= play_val;
    end

    assign igual = (R == mem[E]);
    assign fimE  = (E == L);
    assign fimL  = (L == 2'd3);

    // Reference game model: current step code and cycles spent waiting
    int m_st, m_t, m_nx;
    bit m_ok = 1'b0;

    always @(posedge clock) begin
        if (reset) begin
            m_st <= 0;
            m_t  <= 0;
            m_ok <= 1'b1;
        end else begin
            m_nx = 0;
            case (m_st)
                0:          m_nx = iniciar ? 1 : 0;
                1:          m_nx = 2;
                2:          m_nx = 3;
                3:          m_nx = jogada ? 4 : ((m_t == T - 1) ? 12 : 3);
                4:          m_nx = 5;
                5:          m_nx = !igual ? 14 : (!fimE ? 6 : (!fimL ? 7 : 10));
                6:          m_nx = 3;
                7:          m_nx = 2;
                10, 12, 14: m_nx = iniciar ? 1 : m_st;
                default:    m_nx = 0;
            endcase
            m_t  <= (m_st == 3 && m_nx == 3) ? m_t + 1 : 0;
            m_st <= m_nx;
        end
    end

    // {zeraE,contaE,zeraL,contaL,zeraR,registraR,pronto,ganhou,perdeu,timeout}
    function automatic logic [9:0] exp_out(int st);
        case (st)
            0, 1:    return 10'b1010100000;
            2:       return 10'b1000000000;
            4:       return 10'b0000010000;
            6:       return 10'b0100000000;
            7:       return 10'b0001000000;
            10:      return 10'b0000001100;
            14:      return 10'b0000001010;
            12:      return 10'b0000001011;
            default: return 10'b0000000000;
        endcase
    endfunction

    int n_assert = 0;
    int n_fail   = 0;
    int n_contaL = 0;
    int n_contaE = 0;
    int n_regR   = 0;

    logic [9:0] dut_vec;
    assign dut_vec = {zeraE, contaE, zeraL, contaL, zeraR, registraR,
                      pronto, ganhou, perdeu, timeout};

    // Advance one cycle and compare the DUT against the model
    task automatic tick();
        @(negedge clock);
        if (m_ok) begin
            n_assert++;
            if (db_estado !== 4'(m_st) || dut_vec !== exp_out(m_st)) begin
                n_fail++;
                $display("FAIL model t=%0t: db_estado=%h outs=%b, required db_estado=%h outs=%b",
                         $time, db_estado, dut_vec, 4'(m_st), exp_out(m_st));
            end
        end
        n_contaL += int'(contaL);
        n_contaE += int'(contaE);
        n_regR   += int'(registraR);
    endtask

    task automatic check(string name, logic [31:0] act, logic [31:0] req);
        n_assert++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic wait_state(logic [3:0] code, int budget);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (db_estado == code) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        if (!seen && db_estado != code) begin
            n_assert++;
            n_fail++;
            $display("FAIL wait_state: got %h, required %h within %0d cycles",
                     db_estado, code, budget);
        end
    endtask

    // Wait for the play state, then make a play (correct or wrong) on cycle 3
    task automatic jogar(bit ok);
        wait_state(4'(ESPERA_JOGADA), 40);
        tick();
        tick();
        play_val = ok ? mem[E] : ~mem[E];
        jogada   = 1'b1;
        tick();
        jogada   = 1'b0;
    endtask

    task automatic pulso_iniciar();
        iniciar = 1'b1;
        tick();
        iniciar = 1'b0;
    endtask

    initial begin
        int base_l, base_r, base_e, n3;
        mem[0] = 4'h3;
        mem[1] = 4'h9;
        mem[2] = 4'h5;
        mem[3] = 4'hC;
        reset    = 1'b1;
        iniciar  = 1'b0;
        jogada   = 1'b0;
        play_val = 4'h0;
        tick();
        reset = 1'b0;

        // Reset state
        check("reset_db_estado", db_estado, 4'h0);
        check("reset_zeraE", zeraE, 1'b1);
        check("reset_zeraL", zeraL, 1'b1);
        check("reset_zeraR", zeraR, 1'b1);
        check("reset_pronto", pronto, 1'b0);

        // Full winning game: rounds 0..3, 10 correct plays
        pulso_iniciar();
        base_l = n_contaL;
        base_r = n_regR;
        for (int k = 0; k < 4; k++) begin
            for (int j = 0; j <= k; j++) begin
                jogar(1'b1);
            end
        end
        wait_state(4'(FINAL_ACERTOU), 20);
        check("win_contaL_pulses", n_contaL - base_l, 3);
        check("win_registraR_pulses", n_regR - base_r, 10);
        check("win_db_estado", db_estado, 4'hA);
        check("win_ganhou", ganhou, 1'b1);
        check("win_pronto", pronto, 1'b1);
        check("win_perdeu", perdeu, 1'b0);

        // Restart from the win state
        pulso_iniciar();
        check("restart_db_1", db_estado, 4'h1);
        check("restart_zeraE_1", zeraE, 1'b1);
        check("restart_zeraL_1", zeraL, 1'b1);
        tick();
        check("restart_db_2", db_estado, 4'h2);
        check("restart_zeraE_2", zeraE, 1'b1);
        check("restart_zeraL_2", zeraL, 1'b0);
        tick();
        check("restart_db_3", db_estado, 4'h3);

        // Miss on the second play of round 1
        jogar(1'b1);
        jogar(1'b1);
        jogar(1'b0);
        wait_state(4'(FINAL_ERROU), 10);
        base_e = n_contaE;
        check("miss_db_estado", db_estado, 4'hE);
        check("miss_perdeu", perdeu, 1'b1);
        check("miss_timeout", timeout, 1'b0);
        check("miss_ganhou", ganhou, 1'b0);
        repeat (5) tick();
        check("miss_no_contaE", n_contaE - base_e, 0);
        check("miss_hold", db_estado, 4'hE);

        // Timeout with no play: exactly T cycles in the wait state
        pulso_iniciar();
        wait_state(4'(ESPERA_JOGADA), 10);
        n3 = 1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (db_estado == 4'h3) n3++;
            else break;
        end
        check("timeout_cycles_in_3", n3, T);
        check("timeout_db_estado", db_estado, 4'hC);
        check("timeout_flag", timeout, 1'b1);
        check("timeout_perdeu", perdeu, 1'b1);
        check("timeout_pronto", pronto, 1'b1);

        // Play on the expiry cycle wins over the timeout
        pulso_iniciar();
        wait_state(4'(ESPERA_JOGADA), 10);
        repeat (T - 1) tick();
        play_val = mem[E];
        jogada   = 1'b1;
        tick();
        jogada   = 1'b0;
        check("late_play_db_estado", db_estado, 4'h4);

        // A play pulse while registering is ignored
        base_r = n_regR;
        jogada = 1'b1;
        tick();
        jogada = 1'b0;
        check("play_in_4_db_estado", db_estado, 4'h5);
        wait_state(4'(ESPERA_JOGADA), 10);
        check("play_in_4_no_registraR", n_regR - base_r, 0);

        // Reset taken in proxima_jogada
        jogar(1'b1);
        wait_state(4'(PROXIMA_JOGADA), 10);
        check("pre_reset_db_estado", db_estado, 4'h6);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midgame_reset_db_estado", db_estado, 4'h0);
        check("midgame_reset_zeraE", zeraE, 1'b1);
        check("midgame_reset_pronto", pronto, 1'b0);
        tick();
        check("idle_after_reset", db_estado, 4'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
